// File: rtl/ngram_window_encoder.sv
// ngram_window_encoder: binds the last NGRAM spatial HVs into an N-gram and bundles WINDOW N-grams by majority
// Ports:
//   Clk_CI            clock, rising edge
//   Reset_RI          async reset, active high
//   ValidIn_SI        HypervectorIn_DI valid
//   ReadyOut_SO       block can accept an input this cycle (low only while an output is pending)
//   HypervectorIn_DI  spatial HV from upstream
//   ValidOut_SO       HypervectorOut_DO valid (registered)
//   ReadyIn_SI        downstream accepts the output this cycle
//   HypervectorOut_DO bundled temporal HV (registered, held until the next window completes)
// Option macro NGRAM_TIEBREAK_EN: exact ties take the bit of the window's final bind instead of 0.
module ngram_window_encoder #(
    parameter int HV_DIM = 2048,
    parameter int NGRAM  = 3,
    parameter int WINDOW = 5,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              Clk_CI,
    input  logic              Reset_RI,
    input  logic              ValidIn_SI,
    output logic              ReadyOut_SO,
    input  logic [0:HV_DIM-1] HypervectorIn_DI,
    output logic              ValidOut_SO,
    input  logic              ReadyIn_SI,
    output logic [0:HV_DIM-1] HypervectorOut_DO
);
    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    // With NGRAM=1 there is nothing to prefill, so every window starts directly in ACCUM.
    localparam logic [1:0] START = (NGRAM == 1) ? ACCUM : FILL;
    localparam int NS = (NGRAM > 1) ? NGRAM - 1 : 1;
    localparam int FW = (NGRAM > 2) ? $clog2(NGRAM) : 1;
    localparam logic [CNT_W+1:0] W2 = (CNT_W + 2)'(WINDOW);

    logic [1:0]        state;
    logic [FW-1:0]     fillCnt;
    logic [CNT_W-1:0]  winCnt;
    logic [0:HV_DIM-1] stage [NS];
    logic [CNT_W-1:0]  cnt [HV_DIM];
    logic [CNT_W:0]    nxt [HV_DIM];
    logic [0:HV_DIM-1] bindHv;
    logic [0:HV_DIM-1] maj;
    logic              accept;
    logic              lastAcc;

    function automatic logic [0:HV_DIM-1] rotr1(input logic [0:HV_DIM-1] x);
        return {x[HV_DIM-1], x[0:HV_DIM-2]};
    endfunction

    assign ReadyOut_SO = (state != EMIT);
    assign accept      = ValidIn_SI && ReadyOut_SO;
    assign lastAcc     = (winCnt == CNT_W'(WINDOW - 1));

    // Bind of the N-gram that will sit in the stages after this accept.
    always_comb begin
        bindHv = HypervectorIn_DI;
        for (int k = 0; k < NGRAM - 1; k++) bindHv = bindHv ^ rotr1(stage[k]);
        bindHv = ~bindHv;
    end

    always_comb begin
        for (int b = 0; b < HV_DIM; b++) begin
            nxt[b] = {1'b0, cnt[b]} + {{CNT_W{1'b0}}, bindHv[b]};
`ifdef NGRAM_TIEBREAK_EN
            maj[b] = ({nxt[b], 1'b0} > W2) ? 1'b1 : ({nxt[b], 1'b0} == W2) ? bindHv[b] : 1'b0;
`else
            maj[b] = ({nxt[b], 1'b0} > W2);
`endif
        end
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state             <= START;
            fillCnt           <= '0;
            winCnt            <= '0;
            ValidOut_SO       <= 1'b0;
            HypervectorOut_DO <= '0;
            for (int b = 0; b < HV_DIM; b++) cnt[b] <= '0;
            for (int k = 0; k < NS; k++) stage[k] <= '0;
        end else begin
            if (accept) begin
                stage[0] <= HypervectorIn_DI;
                for (int k = 1; k < NS; k++) stage[k] <= rotr1(stage[k-1]);
            end
            if (state == EMIT) begin
                if (ReadyIn_SI) begin
                    ValidOut_SO <= 1'b0;
                    state       <= START;
                end
            end else if (accept && state == FILL) begin
                fillCnt <= fillCnt + FW'(1);
                if (fillCnt == FW'(NGRAM - 2)) state <= ACCUM;
            end else if (accept) begin
                if (lastAcc) begin
                    HypervectorOut_DO <= maj;
                    ValidOut_SO       <= 1'b1;
                    winCnt            <= '0;
                    fillCnt           <= '0;
                    state             <= EMIT;
                    for (int b = 0; b < HV_DIM; b++) cnt[b] <= '0;
                end else begin
                    winCnt <= winCnt + CNT_W'(1);
                    for (int b = 0; b < HV_DIM; b++) cnt[b] <= nxt[b][CNT_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_ngram_window_encoder.sv
// tb_ngram_window_encoder: directed checks of three encoder configurations (HV_DIM=8)
module tb_ngram_window_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vA = 0, rdyA, voA, riA = 0;
    logic       vB = 0, rdyB, voB, riB = 0;
    logic       vC = 0, rdyC, voC, riC = 0;
    logic [0:7] dA = 0, oA, dB = 0, oB, dC = 0, oC;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    ngram_window_encoder #(.HV_DIM(8), .NGRAM(2), .WINDOW(3)) uA (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vA), .ReadyOut_SO(rdyA), .HypervectorIn_DI(dA),
        .ValidOut_SO(voA), .ReadyIn_SI(riA), .HypervectorOut_DO(oA));
    ngram_window_encoder #(.HV_DIM(8), .NGRAM(1), .WINDOW(3)) uB (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vB), .ReadyOut_SO(rdyB), .HypervectorIn_DI(dB),
        .ValidOut_SO(voB), .ReadyIn_SI(riB), .HypervectorOut_DO(oB));
    ngram_window_encoder #(.HV_DIM(8), .NGRAM(1), .WINDOW(2)) uC (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vC), .ReadyOut_SO(rdyC), .HypervectorIn_DI(dC),
        .ValidOut_SO(voC), .ReadyIn_SI(riC), .HypervectorOut_DO(oC));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendA(input logic [7:0] d);
        vA = 1; dA = d; tick(); vA = 0;
    endtask

    task automatic sendB(input logic [7:0] d);
        vB = 1; dB = d; tick(); vB = 0;
    endtask

    task automatic sendC(input logic [7:0] d);
        vC = 1; dC = d; tick(); vC = 0;
    endtask

    initial begin
        logic [7:0] tieExp;
`ifdef NGRAM_TIEBREAK_EN
        tieExp = 8'h0F;
`else
        tieExp = 8'h00;
`endif
        tick(); tick();
        chk("rst_valid", voA, 0);
        chk("rst_out", oA, 8'h00);
        chk("rst_ready", rdyA, 1);
        rst = 0;
        tick();
        // back-to-back window of 8'h01 (NGRAM=2, WINDOW=3)
        sendA(8'h01); chk("b2b_v1", voA, 0);
        sendA(8'h01); chk("b2b_v2", voA, 0);
        sendA(8'h01); chk("b2b_v3", voA, 0);
        sendA(8'h01);
        chk("b2b_valid", voA, 1);
        chk("b2b_out", oA, 8'h7E);
        chk("b2b_ready", rdyA, 0);
        // back-pressure with upstream still presenting data
        vA = 1; dA = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", rdyA, 0);
            chk("bp_valid", voA, 1);
            chk("bp_out", oA, 8'h7E);
        end
        vA = 0; riA = 1;
        tick();
        chk("rel_valid", voA, 0);
        chk("rel_ready", rdyA, 1);
        riA = 0;
        // same window with idle gaps of 1..3 cycles
        sendA(8'h01); tick();
        sendA(8'h01); tick(); tick();
        sendA(8'h01); chk("gap_v3", voA, 0); tick(); tick(); tick();
        chk("gap_idle", voA, 0);
        sendA(8'h01);
        chk("gap_valid", voA, 1);
        chk("gap_out", oA, 8'h7E);
        riA = 1; tick(); riA = 0;
        // abort mid-window with reset asserted between edges
        sendA(8'h01); sendA(8'hFF); sendA(8'hFF);
        #3 rst = 1;
        #1;
        chk("async_out", oA, 8'h00);
        chk("async_ready", rdyA, 1);
        tick(); rst = 0; tick();
        sendA(8'h01); sendA(8'h01);
        sendA(8'h01); chk("abort_v3", voA, 0);
        sendA(8'h01);
        chk("abort_valid", voA, 1);
        chk("abort_out", oA, 8'h7E);
        riA = 1; tick(); riA = 0;
        // NGRAM=1, WINDOW=3: binds FF, FF, 00
        sendB(8'h00); sendB(8'h00); chk("n1_v2", voB, 0);
        sendB(8'hFF);
        chk("n1_valid", voB, 1);
        chk("n1_out", oB, 8'hFF);
        // pending output discarded by an async reset
        #3 rst = 1;
        #1;
        chk("async_pend_valid", voB, 0);
        chk("async_pend_out", oB, 8'h00);
        tick(); rst = 0; tick();
        // NGRAM=1, WINDOW=2: all-tie window, then a non-tie window
        sendC(8'h0F); sendC(8'hF0);
        chk("tie_valid", voC, 1);
        chk("tie_out", oC, tieExp);
        riC = 1; tick(); riC = 0;
        chk("tie_rel", voC, 0);
        sendC(8'h0F); sendC(8'h0F);
        chk("even_out", oC, 8'hF0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
